// File: rtl/ritc_vdd_servo_dac_pkg.sv
// Shared definitions for the VDD servo DAC receiver: frame field positions,
// FSM state encodings, the default DAC command and a frame builder.
package ritc_vdd_servo_dac_pkg;

    localparam int CMD_MSB = 15;
    localparam int CH_BIT  = 12;
    localparam int DATA_W  = 12;
    localparam int FRAME_W = 16;

    // Write-and-update command for the dual-channel VDD DAC.
    localparam logic [2:0] DAC_CMD_DEFAULT = 3'b011;

    // Sequencer states of the top level.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_LEAD  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_GAP   = 3'd4,
        ST_FIN   = 3'd5
    } servo_state_t;

    // Phases of one serial frame inside the shifter.
    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_LEAD = 2'd1,
        PH_HIGH = 2'd2,
        PH_LOW  = 2'd3
    } spi_phase_t;

    // Assemble {cmd, ch, data} into one DAC frame.
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic [2:0]        cmd,
        input logic              ch,
        input logic [DATA_W-1:0] data
    );
        logic [FRAME_W-1:0] f;
        f                  = {FRAME_W{1'b0}};
        f[CMD_MSB -: 3]    = cmd;
        f[CH_BIT]          = ch;
        f[DATA_W-1:0]      = data;
        return f;
    endfunction

endpackage

// File: rtl/ritc_dac_spi_shifter.sv
// Sends one SYNC-framed 16-bit word to the DAC: a LEAD phase with SYNC low,
// then 16 bits MSB first, each bit CLK_DIV cycles SCLK high then CLK_DIV low.
// frame_done marks the last cycle of the frame, so the sequencer can act on
// the same edge where SYNC returns high.
module ritc_dac_spi_shifter
    import ritc_vdd_servo_dac_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] word,
    output logic        sclk,
    output logic        sync_n,
    output logic        din,
    output logic        frame_done,
    output logic        shifting
);

    localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);

    spi_phase_t  phase_r, phase_s;
    logic [7:0]  cnt_r, cnt_s;
    logic [4:0]  bit_r, bit_s;
    logic [14:0] shreg_r, shreg_s;
    logic        sclk_r, sclk_s;
    logic        sync_n_r, sync_n_s;
    logic        din_r, din_s;
    logic        frame_done_r, frame_done_s;

    // Next-state logic for the frame phases, counters and pin values.
    always_comb begin
        phase_s  = phase_r;
        cnt_s    = cnt_r;
        bit_s    = bit_r;
        shreg_s  = shreg_r;
        sclk_s   = sclk_r;
        sync_n_s = sync_n_r;
        din_s    = din_r;
        case (phase_r)
            PH_IDLE: begin
                if (start) begin
                    phase_s  = PH_LEAD;
                    cnt_s    = DIV_LOAD;
                    bit_s    = 5'd0;
                    shreg_s  = word[14:0];
                    sync_n_s = 1'b0;
                    sclk_s   = 1'b0;
                    din_s    = word[15];
                end else begin
                    phase_s  = PH_IDLE;
                end
            end
            PH_LEAD: begin
                if (cnt_r == 8'd0) begin
                    phase_s = PH_HIGH;
                    cnt_s   = DIV_LOAD;
                    sclk_s  = 1'b1;
                end else begin
                    cnt_s   = cnt_r - 8'd1;
                end
            end
            PH_HIGH: begin
                if (cnt_r == 8'd0) begin
                    phase_s = PH_LOW;
                    cnt_s   = DIV_LOAD;
                    sclk_s  = 1'b0;
                    if (bit_r != 5'd15) begin
                        din_s   = shreg_r[14];
                        shreg_s = {shreg_r[13:0], 1'b0};
                    end else begin
                        din_s   = din_r;
                    end
                end else begin
                    cnt_s   = cnt_r - 8'd1;
                end
            end
            PH_LOW: begin
                if (cnt_r == 8'd0) begin
                    if (bit_r == 5'd15) begin
                        phase_s  = PH_IDLE;
                        sync_n_s = 1'b1;
                        sclk_s   = 1'b0;
                        din_s    = 1'b0;
                    end else begin
                        phase_s  = PH_HIGH;
                        cnt_s    = DIV_LOAD;
                        sclk_s   = 1'b1;
                        bit_s    = bit_r + 5'd1;
                    end
                end else begin
                    cnt_s = cnt_r - 8'd1;
                end
            end
            default: begin
                phase_s  = PH_IDLE;
                sync_n_s = 1'b1;
                sclk_s   = 1'b0;
                din_s    = 1'b0;
            end
        endcase
        frame_done_s = (phase_s == PH_LOW) && (cnt_s == 8'd0) && (bit_s == 5'd15);
    end

    // State and pin registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_r      <= PH_IDLE;
            cnt_r        <= 8'd0;
            bit_r        <= 5'd0;
            shreg_r      <= 15'd0;
            sclk_r       <= 1'b0;
            sync_n_r     <= 1'b1;
            din_r        <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            phase_r      <= phase_s;
            cnt_r        <= cnt_s;
            bit_r        <= bit_s;
            shreg_r      <= shreg_s;
            sclk_r       <= sclk_s;
            sync_n_r     <= sync_n_s;
            din_r        <= din_s;
            frame_done_r <= frame_done_s;
        end
    end

    assign sclk       = sclk_r;
    assign sync_n     = sync_n_r;
    assign din        = din_r;
    assign frame_done = frame_done_r;
    assign shifting   = (phase_r == PH_HIGH) || (phase_r == PH_LOW);

endmodule

// File: rtl/ritc_vdd_servo_dac.sv
// Receiving end of the phase-scanner servo interface. Holds RITC0/RITC1 shadow
// words, snapshots both on a load request and sends them to the dual-channel
// VDD DAC as two SYNC-framed words separated by a SYNC_GAP idle.
module ritc_vdd_servo_dac
    import ritc_vdd_servo_dac_pkg::*;
#(
    parameter int         CLK_DIV  = 4,
    parameter int         SYNC_GAP = 2,
    parameter logic [2:0] DAC_CMD  = DAC_CMD_DEFAULT
) (
    input  logic        user_clk_i,
    input  logic        user_rst_n_i,
    input  logic        servo_addr_i,
    input  logic        servo_wr_i,
    input  logic        servo_update_i,
    input  logic [11:0] servo_i,
    output logic        dac_sclk_o,
    output logic        dac_sync_n_o,
    output logic        dac_din_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [11:0] vdd_r0_o,
    output logic [11:0] vdd_r1_o
);

    localparam logic [7:0] GAP_LOAD = 8'(SYNC_GAP - 1);

    servo_state_t state_r;
    logic [11:0]  shadow0_r, shadow1_r;
    logic [11:0]  vdd_r0_r, vdd_r1_r;
    logic         pending_r;
    logic         busy_r;
    logic         done_r;
    logic         frame_sel_r;
    logic [7:0]   gap_cnt_r;

    logic         start_s;
    logic [15:0]  word_s;
    logic         frame_done_s;
    logic         shifting_s;

    // Frame start strobe and word select: channel 0 after LOAD, channel 1 after GAP.
    always_comb begin
        start_s = 1'b0;
        word_s  = build_frame(DAC_CMD, 1'b0, vdd_r0_r);
        if (state_r == ST_LOAD) begin
            start_s = 1'b1;
        end else if (state_r == ST_GAP) begin
            start_s = (gap_cnt_r == 8'd0);
            word_s  = build_frame(DAC_CMD, 1'b1, vdd_r1_r);
        end else begin
            start_s = 1'b0;
        end
    end

    // Shadow registers accept writes in every state.
    always_ff @(posedge user_clk_i) begin
        if (!user_rst_n_i) begin
            shadow0_r <= 12'd0;
            shadow1_r <= 12'd0;
        end else if (servo_wr_i) begin
            if (servo_addr_i) begin
                shadow1_r <= servo_i;
            end else begin
                shadow0_r <= servo_i;
            end
        end
    end

    // Sequencer: snapshot, two frames with a gap, pending reload, done pulse.
    always_ff @(posedge user_clk_i) begin
        if (!user_rst_n_i) begin
            state_r     <= ST_IDLE;
            vdd_r0_r    <= 12'd0;
            vdd_r1_r    <= 12'd0;
            pending_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            frame_sel_r <= 1'b0;
            gap_cnt_r   <= 8'd0;
        end else begin
            done_r <= 1'b0;
            if (servo_update_i && (state_r != ST_IDLE)) begin
                pending_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (servo_update_i || pending_r) begin
                        state_r     <= ST_LOAD;
                        vdd_r0_r    <= shadow0_r;
                        vdd_r1_r    <= shadow1_r;
                        busy_r      <= 1'b1;
                        pending_r   <= 1'b0;
                        frame_sel_r <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    state_r <= ST_LEAD;
                end
                ST_LEAD: begin
                    if (shifting_s) begin
                        state_r <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (frame_done_s) begin
                        if (!frame_sel_r) begin
                            state_r     <= ST_GAP;
                            gap_cnt_r   <= GAP_LOAD;
                            frame_sel_r <= 1'b1;
                        end else if (pending_r) begin
                            // Queued request: reload straight away, no done pulse.
                            state_r     <= ST_LOAD;
                            vdd_r0_r    <= shadow0_r;
                            vdd_r1_r    <= shadow1_r;
                            pending_r   <= 1'b0;
                            frame_sel_r <= 1'b0;
                        end else begin
                            state_r <= ST_FIN;
                            done_r  <= 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r == 8'd0) begin
                        state_r <= ST_LEAD;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - 8'd1;
                    end
                end
                ST_FIN: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    ritc_dac_spi_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk        (user_clk_i),
        .rst_n      (user_rst_n_i),
        .start      (start_s),
        .word       (word_s),
        .sclk       (dac_sclk_o),
        .sync_n     (dac_sync_n_o),
        .din        (dac_din_o),
        .frame_done (frame_done_s),
        .shifting   (shifting_s)
    );

    assign busy_o   = busy_r;
    assign done_o   = done_r;
    assign vdd_r0_o = vdd_r0_r;
    assign vdd_r1_o = vdd_r1_r;

endmodule
